// File: rtl/seq_div.sv
// Restoring shift-subtract unsigned divider.
// One quotient bit per clock, go/done handshake.
module seq_div #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         go,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  q_r;
  logic [W-1:0]  d_r;
  logic [W-1:0]  r_r;
  logic [CW-1:0] cnt;

  logic [W:0]    trial;
  logic [W-1:0]  q_nxt;
  logic [W-1:0]  r_nxt;

  // R < D always holds, so the W+1 bit trial cannot overflow
  always_comb begin
    trial = {r_r, q_r[W-1]} - {1'b0, d_r};
    q_nxt = {q_r[W-2:0], 1'b0};
    r_nxt = {r_r[W-2:0], q_r[W-1]};
    if (!trial[W]) begin
      q_nxt = {q_r[W-2:0], 1'b1};
      r_nxt = trial[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      q_r         <= '0;
      d_r         <= '0;
      r_r         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            q_r         <= dividend;
            d_r         <= divisor;
            r_r         <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (d_r == '0) begin
            quotient    <= '1;
            remainder   <= q_r;
            div_by_zero <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            cnt   <= CW'(W - 1);
            state <= CALC;
          end
        end
        CALC: begin
          q_r <= q_nxt;
          r_r <= r_nxt;
          if (cnt == '0) begin
            quotient  <= q_nxt;
            remainder <= r_nxt;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div (W=4): latency,
// results, abort, ignored go and full sweep.
module tb_seq_div;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic         go;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  typedef struct {
    int q;
    int r;
    int z;
    int a;
    int b;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   last_q = 0;
  int   last_r = 0;

  seq_div #(.W(W)) dut (
    .clk         (clk),
    .clr         (clr),
    .go          (go),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. poke>=0 pulses
  // a stray go with other operands that many edges in.
  task automatic run(input int a, input int b, input int poke);
    exp_t e;
    int   n;
    int   lat;
    go       = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    e.a = a;
    e.b = b;
    e.q = (b == 0) ? 15 : a / b;
    e.r = (b == 0) ? a : a % b;
    e.z = (b == 0) ? 1 : 0;
    sb.push_back(e);
    lat = (b == 0) ? 1 : W + 1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    n  = 0;
    chk("dbz_clear", div_by_zero, 0);
    while (!done && n < 40) begin
      chk("busy", busy, 1);
      chk("q_hold", quotient, last_q);
      chk("r_hold", remainder, last_r);
      if (n == poke) begin
        go       = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd2;
      end else begin
        go = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    go = 1'b0;
    chk("latency", n, lat);
    if (done) begin
      chk("busy_in_done", busy, 0);
      if (sb.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.z);
        if (e.b != 0) begin
          chk("inv_sum", quotient * e.b + remainder, e.a);
          chk("inv_rlt", (remainder < e.b) ? 1 : 0, 1);
        end
      end
      last_q = quotient;
      last_r = remainder;
    end
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    clr      = 1'b1;
    go       = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);

    run(13, 3, -1);
    run(15, 1, -1);
    run(7, 9, -1);
    run(0, 5, -1);
    run(9, 0, -1);
    run(6, 2, -1);
    run(13, 3, 2);

    // abort mid-CALC
    go       = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    @(posedge clk);
    @(negedge clk);
    go       = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_q", quotient, 0);
    chk("clr_r", remainder, 0);
    chk("clr_dbz", div_by_zero, 0);
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      chk("clr_no_done", done, 0);
    end
    last_q = 0;
    last_r = 0;
    run(12, 5, -1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run(a, b, -1);
      end
    end

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
